// File: rtl/phy_link_supervisor_if.sv
// Control/status bundle between the PHY link supervisor and its environment.
// The slave modport is the supervisor side; the master modport is the board/reset-controller side.
interface phy_link_supervisor_if;
  logic       link_up;
  logic       soft_rst_req;
  logic       phy_reset_n;
  logic       mac_reset;
  logic       link_ready;
  logic       fail;
  logic [7:0] retry_count;
  logic [7:0] loss_count;
  logic [2:0] state;

  modport master (
    output link_up, soft_rst_req,
    input  phy_reset_n, mac_reset, link_ready, fail, retry_count, loss_count, state
  );

  modport slave (
    input  link_up, soft_rst_req,
    output phy_reset_n, mac_reset, link_ready, fail, retry_count, loss_count, state
  );
endinterface

// File: rtl/phy_link_supervisor.sv
// PHY/MAC bring-up sequencer: PHY reset, settle, wait for link with retries, then run.
// Optional link-loss recovery in RUN is built when LINK_LOSS_RECOVERY_EN is defined.
module phy_link_supervisor #(
  parameter logic [31:0] RESET_CYCLES  = 32'd10_000_000,
  parameter logic [31:0] SETTLE_CYCLES = 32'd5_000_000,
  parameter logic [31:0] LINK_TIMEOUT  = 32'd50_000_000,
  parameter logic [7:0]  MAX_RETRIES   = 8'd3,
  parameter logic [31:0] LOSS_DEBOUNCE = 32'd1_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  phy_link_supervisor_if.slave  bus
);

  typedef enum logic [2:0] {
    PHY_RST   = 3'd0,
    SETTLE    = 3'd1,
    WAIT_LINK = 3'd2,
    RUN       = 3'd3,
    S_FAIL    = 3'd4
  } state_e;

  if (RESET_CYCLES == 32'd0 || SETTLE_CYCLES == 32'd0 ||
      LINK_TIMEOUT == 32'd0 || LOSS_DEBOUNCE == 32'd0) begin : g_cfg_check
    $error("phy_link_supervisor: cycle-count parameters must be >= 1");
  end

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
  logic        link_meta_q, link_s_q;
  logic        phy_reset_n_q, phy_reset_n_d;
  logic        mac_reset_q, mac_reset_d;
  logic        link_ready_q, link_ready_d;
  logic        fail_q, fail_d;

`ifdef LINK_LOSS_RECOVERY_EN
  logic [31:0] loss_run_q, loss_run_d;
  logic [7:0]  loss_count_q, loss_count_d;
`endif

  // link_up is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_meta_q <= 1'b0;
      link_s_q    <= 1'b0;
    end else begin
      link_meta_q <= bus.link_up;
      link_s_q    <= link_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
`ifdef LINK_LOSS_RECOVERY_EN
    loss_run_d   = loss_run_q;
    loss_count_d = loss_count_q;
`endif

    case (state_q)
      PHY_RST:   if (timer_q == RESET_CYCLES - 32'd1) state_d = SETTLE;
      SETTLE:    if (timer_q == SETTLE_CYCLES - 32'd1) state_d = WAIT_LINK;
      WAIT_LINK: begin
        if (link_s_q) begin
          state_d = RUN;
        end else if (timer_q == LINK_TIMEOUT - 32'd1) begin
          if (retry_q < MAX_RETRIES) begin
            retry_d = retry_q + 8'd1;
            state_d = PHY_RST;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      RUN: begin
`ifdef LINK_LOSS_RECOVERY_EN
        if (link_s_q) begin
          loss_run_d = 32'd0;
        end else if (loss_run_q == LOSS_DEBOUNCE - 32'd1) begin
          state_d = PHY_RST;
          retry_d = 8'd0;
          if (loss_count_q != 8'hFF) loss_count_d = loss_count_q + 8'd1;
        end else begin
          loss_run_d = loss_run_q + 32'd1;
        end
`endif
      end
      S_FAIL:  ;
      default: state_d = PHY_RST;
    endcase

    // A soft restart overrides every transition above, but a drop counted on the same edge is not kept
    if (bus.soft_rst_req) begin
      state_d = PHY_RST;
      retry_d = 8'd0;
`ifdef LINK_LOSS_RECOVERY_EN
      loss_count_d = loss_count_q;
`endif
    end

`ifdef LINK_LOSS_RECOVERY_EN
    if (state_d != RUN) loss_run_d = 32'd0;
`endif

    timer_d = (state_d != state_q || bus.soft_rst_req) ? 32'd0 : timer_q + 32'd1;

    // Outputs decode the next state so they change on the edge that enters it
    phy_reset_n_d = (state_d == SETTLE) || (state_d == WAIT_LINK) || (state_d == RUN);
    mac_reset_d   = (state_d != RUN);
    link_ready_d  = (state_d == RUN) && link_s_q;
    fail_d        = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PHY_RST;
      timer_q       <= 32'd0;
      retry_q       <= 8'd0;
      phy_reset_n_q <= 1'b0;
      mac_reset_q   <= 1'b1;
      link_ready_q  <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      phy_reset_n_q <= phy_reset_n_d;
      mac_reset_q   <= mac_reset_d;
      link_ready_q  <= link_ready_d;
      fail_q        <= fail_d;
    end
  end

`ifdef LINK_LOSS_RECOVERY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_run_q   <= 32'd0;
      loss_count_q <= 8'd0;
    end else begin
      loss_run_q   <= loss_run_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign bus.loss_count = loss_count_q;
`else
  assign bus.loss_count = 8'd0;
`endif

  assign bus.phy_reset_n = phy_reset_n_q;
  assign bus.mac_reset   = mac_reset_q;
  assign bus.link_ready  = link_ready_q;
  assign bus.fail        = fail_q;
  assign bus.retry_count = retry_q;
  assign bus.state       = state_q;

endmodule
